// File: rtl/lcd_bus_reader.sv
// HD44780-style LCD read-cycle engine: status/data reads with optional busy-flag polling.
// Define LCD_READ_4BIT_EN for the 4-bit interface (two E pulses per byte).
module lcd_bus_reader #(
  parameter int unsigned MFREQ_KHZ       = 1,
  parameter int unsigned SETUP_CYC       = 2,
  parameter int unsigned E_HIGH_CYC      = 4,
  parameter int unsigned HOLD_CYC        = 2,
  parameter logic [15:0] POLL_TIMEOUT_MS = 16'd10
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       req,
  input  logic       rd_data_sel,
  input  logic       poll_bf,
  input  logic [7:0] DB_in,
  output logic       ready,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       bus_own,
  output logic       E,
  output logic       RS,
  output logic       RW
);

  localparam int unsigned PH_W  = 16;
  localparam int unsigned CLK_W = (MFREQ_KHZ > 1) ? $clog2(MFREQ_KHZ) : 1;
  localparam int unsigned MS_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EHIGH = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t           state;
  logic [PH_W-1:0]  ph_cnt;
  logic [CLK_W-1:0] clk_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             sel_q;
  logic             poll_q;

  logic             ph_last_setup;
  logic             ph_last_ehigh;
  logic             ph_last_hold;
  logic             timed_out;
  logic [7:0]       cap_byte;

  assign ph_last_setup = (ph_cnt == PH_W'(SETUP_CYC - 1));
  assign ph_last_ehigh = (ph_cnt == PH_W'(E_HIGH_CYC - 1));
  assign ph_last_hold  = (ph_cnt == PH_W'(HOLD_CYC - 1));
  assign timed_out     = (ms_cnt >= POLL_TIMEOUT_MS);

`ifdef LCD_READ_4BIT_EN
  logic       nib_q;
  logic [3:0] hi_nib;
  assign cap_byte = {hi_nib, DB_in[7:4]};
`else
  assign cap_byte = DB_in;
`endif

  always_ff @(posedge mclk) begin
    if (rst) begin
      state     <= IDLE;
      ph_cnt    <= '0;
      clk_cnt   <= '0;
      ms_cnt    <= '0;
      sel_q     <= 1'b0;
      poll_q    <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      rd_data   <= '0;
      busy_flag <= 1'b0;
      addr_cnt  <= '0;
      bus_own   <= 1'b0;
      E         <= 1'b0;
      RS        <= 1'b0;
      RW        <= 1'b0;
`ifdef LCD_READ_4BIT_EN
      nib_q     <= 1'b0;
      hi_nib    <= '0;
`endif
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;

      // Poll timeout clock: only advances while a polling read is in flight
      if (poll_q && (state != IDLE)) begin
        if (clk_cnt == CLK_W'(MFREQ_KHZ - 1)) begin
          clk_cnt <= '0;
          if (ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;
        end else begin
          clk_cnt <= clk_cnt + CLK_W'(1);
        end
      end

      case (state)
        IDLE: begin
          ready   <= 1'b1;
          bus_own <= 1'b0;
          E       <= 1'b0;
          RW      <= 1'b0;
          if (req) begin
            sel_q   <= rd_data_sel;
            poll_q  <= poll_bf & ~rd_data_sel;
            clk_cnt <= '0;
            ms_cnt  <= '0;
            ph_cnt  <= '0;
            ready   <= 1'b0;
            bus_own <= 1'b1;
            RW      <= 1'b1;
            RS      <= rd_data_sel;
`ifdef LCD_READ_4BIT_EN
            nib_q   <= 1'b0;
`endif
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (ph_last_setup) begin
            ph_cnt <= '0;
            E      <= 1'b1;
            state  <= EHIGH;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        EHIGH: begin
          if (ph_last_ehigh) begin
            ph_cnt <= '0;
            E      <= 1'b0;
            state  <= HOLD;
`ifdef LCD_READ_4BIT_EN
            if (!nib_q) begin
              hi_nib <= DB_in[7:4];
            end else begin
              rd_data <= cap_byte;
              if (!sel_q) begin
                busy_flag <= cap_byte[7];
                addr_cnt  <= cap_byte[6:0];
              end
            end
`else
            rd_data <= cap_byte;
            if (!sel_q) begin
              busy_flag <= cap_byte[7];
              addr_cnt  <= cap_byte[6:0];
            end
`endif
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        HOLD: begin
          if (ph_last_hold) begin
            ph_cnt <= '0;
`ifdef LCD_READ_4BIT_EN
            if (!nib_q) begin
              // Second nibble pulse follows directly, no new setup phase
              nib_q <= 1'b1;
              E     <= 1'b1;
              state <= EHIGH;
            end else
`endif
            if (poll_q && busy_flag && !timed_out) begin
`ifdef LCD_READ_4BIT_EN
              nib_q <= 1'b0;
`endif
              state <= SETUP;
            end else begin
              done    <= 1'b1;
              timeout <= poll_q & busy_flag & timed_out;
              bus_own <= 1'b0;
              RW      <= 1'b0;
              E       <= 1'b0;
              state   <= FIN;
            end
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        FIN: begin
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          ready   <= 1'b1;
          bus_own <= 1'b0;
          E       <= 1'b0;
          RW      <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader (8-bit build): table of single reads plus poll, timeout and reset sequences.
module tb_lcd_bus_reader;

  logic       mclk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic       rd_data_sel;
  logic       poll_bf;
  logic [7:0] DB_in;

  logic       a_ready, a_done, a_timeout, a_busy_flag, a_bus_own, a_E, a_RS, a_RW;
  logic [7:0] a_rd_data;
  logic [6:0] a_addr_cnt;
  logic       b_ready, b_done, b_timeout, b_busy_flag, b_bus_own, b_E, b_RS, b_RW;
  logic [7:0] b_rd_data;
  logic [6:0] b_addr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 mclk = ~mclk;

  // Long timeout so multi-pulse polls finish on BF rather than on the timer
  lcd_bus_reader #(.MFREQ_KHZ(1), .POLL_TIMEOUT_MS(16'd100)) dut_a (
    .mclk(mclk), .rst(rst), .req(req_a), .rd_data_sel(rd_data_sel), .poll_bf(poll_bf),
    .DB_in(DB_in), .ready(a_ready), .done(a_done), .timeout(a_timeout), .rd_data(a_rd_data),
    .busy_flag(a_busy_flag), .addr_cnt(a_addr_cnt), .bus_own(a_bus_own), .E(a_E), .RS(a_RS), .RW(a_RW)
  );

  lcd_bus_reader #(.MFREQ_KHZ(4), .POLL_TIMEOUT_MS(16'd2)) dut_b (
    .mclk(mclk), .rst(rst), .req(req_b), .rd_data_sel(rd_data_sel), .poll_bf(poll_bf),
    .DB_in(DB_in), .ready(b_ready), .done(b_done), .timeout(b_timeout), .rd_data(b_rd_data),
    .busy_flag(b_busy_flag), .addr_cnt(b_addr_cnt), .bus_own(b_bus_own), .E(b_E), .RS(b_RS), .RW(b_RW)
  );

  typedef struct {
    bit         sel;
    bit         poll;
    logic [7:0] db;
    logic [7:0] exp_rd;
    logic       exp_bf;
    logic [6:0] exp_ac;
    int         exp_lat;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic set_req(input bit inst, input logic v);
    if (inst) req_b = v;
    else      req_a = v;
  endtask

  task automatic sample(input bit inst, output logic r, output logic d, output logic t,
                        output logic e, output logic rs, output logic rw, output logic own,
                        output logic [7:0] rd, output logic bf, output logic [6:0] ac);
    r   = inst ? b_ready     : a_ready;
    d   = inst ? b_done      : a_done;
    t   = inst ? b_timeout   : a_timeout;
    e   = inst ? b_E         : a_E;
    rs  = inst ? b_RS        : a_RS;
    rw  = inst ? b_RW        : a_RW;
    own = inst ? b_bus_own   : a_bus_own;
    rd  = inst ? b_rd_data   : a_rd_data;
    bf  = inst ? b_busy_flag : a_busy_flag;
    ac  = inst ? b_addr_cnt  : a_addr_cnt;
  endtask

  // Issues one request and watches the transaction until done (bounded).
  // DB_in switches from db1 to db2 once nsw E pulses have ended; poke>0 fires a stray req mid-read.
  task automatic do_read(input bit inst, input bit sel, input bit poll,
                         input logic [7:0] db1, input logic [7:0] db2, input int nsw, input int poke,
                         output int lat, output int pulses, output int ehigh,
                         output int bad, output logic to_at_done);
    logic r, d, t, e, rs, rw, own, bf, prev_e;
    logic [7:0] rd;
    logic [6:0] ac;
    int falls;
    DB_in = db1; rd_data_sel = sel; poll_bf = poll;
    set_req(inst, 1'b1);
    tick();
    set_req(inst, 1'b0);
    lat = 0; pulses = 0; ehigh = 0; bad = 0; falls = 0; prev_e = 1'b0; to_at_done = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      sample(inst, r, d, t, e, rs, rw, own, rd, bf, ac);
      if (e) begin
        ehigh++;
        if (!prev_e) pulses++;
      end
      if (prev_e && !e) begin
        falls++;
        if (falls == nsw) DB_in = db2;
      end
      if (d) begin
        lat = c;
        to_at_done = t;
        break;
      end
      if (!own || r || rw !== 1'b1 || rs !== sel) bad++;
      if (poke > 0 && c == poke) begin
        set_req(inst, 1'b1);
        rd_data_sel = ~sel;
      end else begin
        set_req(inst, 1'b0);
      end
      prev_e = e;
      tick();
    end
    set_req(inst, 1'b0);
    rd_data_sel = sel;
  endtask

  task automatic check_after_done(input bit inst, input string name);
    logic r, d, t, e, rs, rw, own, bf;
    logic [7:0] rd;
    logic [6:0] ac;
    tick();
    sample(inst, r, d, t, e, rs, rw, own, rd, bf, ac);
    check({name, "_ready_next"}, {31'd0, r}, 32'd1);
    check({name, "_done_one_cycle"}, {31'd0, d}, 32'd0);
    check({name, "_own_released"}, {30'd0, own, e}, 32'd0);
  endtask

  initial begin : main
    int lat, pulses, ehigh, bad, waited, extra;
    logic to;
    bit found;

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; rd_data_sel = 1'b0; poll_bf = 1'b0; DB_in = 8'h00;
    vecs[0] = '{sel: 1'b0, poll: 1'b0, db: 8'h25, exp_rd: 8'h25, exp_bf: 1'b0, exp_ac: 7'h25, exp_lat: 9, exp_pulses: 1};
    vecs[1] = '{sel: 1'b1, poll: 1'b0, db: 8'h41, exp_rd: 8'h41, exp_bf: 1'b0, exp_ac: 7'h25, exp_lat: 9, exp_pulses: 1};
    vecs[2] = '{sel: 1'b0, poll: 1'b0, db: 8'hA7, exp_rd: 8'hA7, exp_bf: 1'b1, exp_ac: 7'h27, exp_lat: 9, exp_pulses: 1};
    vecs[3] = '{sel: 1'b1, poll: 1'b0, db: 8'h80, exp_rd: 8'h80, exp_bf: 1'b1, exp_ac: 7'h27, exp_lat: 9, exp_pulses: 1};
    vecs[4] = '{sel: 1'b1, poll: 1'b1, db: 8'hFF, exp_rd: 8'hFF, exp_bf: 1'b1, exp_ac: 7'h27, exp_lat: 9, exp_pulses: 1};
    vecs[5] = '{sel: 1'b0, poll: 1'b1, db: 8'h12, exp_rd: 8'h12, exp_bf: 1'b0, exp_ac: 7'h12, exp_lat: 9, exp_pulses: 1};

    tick(); tick(); tick();
    rst = 1'b0;

    check("rst_rd_data", {24'd0, a_rd_data}, 32'd0);
    check("rst_busy_flag", {31'd0, a_busy_flag}, 32'd0);
    check("rst_addr_cnt", {25'd0, a_addr_cnt}, 32'd0);
    check("rst_timeout", {31'd0, a_timeout}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("idle_ready", {31'd0, a_ready}, 32'd1);
      check("idle_ctl", {29'd0, a_E, a_RW, a_bus_own}, 32'd0);
      check("idle_done", {30'd0, a_done, b_done}, 32'd0);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      do_read(1'b0, vecs[i].sel, vecs[i].poll, vecs[i].db, vecs[i].db, 0, 0, lat, pulses, ehigh, bad, to);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
      check($sformatf("v%0d_ehigh_cycles", i), ehigh, 4 * vecs[i].exp_pulses);
      check($sformatf("v%0d_bus_ctl", i), bad, 0);
      check($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
      check($sformatf("v%0d_rd_data", i), {24'd0, a_rd_data}, {24'd0, vecs[i].exp_rd});
      check($sformatf("v%0d_busy_flag", i), {31'd0, a_busy_flag}, {31'd0, vecs[i].exp_bf});
      check($sformatf("v%0d_addr_cnt", i), {25'd0, a_addr_cnt}, {25'd0, vecs[i].exp_ac});
      check_after_done(1'b0, $sformatf("v%0d", i));
    end

    // Poll: busy for three pulses, clear on the fourth
    do_read(1'b0, 1'b0, 1'b1, 8'h80, 8'h03, 3, 0, lat, pulses, ehigh, bad, to);
    check("poll_pulses", pulses, 4);
    check("poll_latency", lat, 33);
    check("poll_bus_ctl", bad, 0);
    check("poll_timeout", {31'd0, to}, 32'd0);
    check("poll_busy_flag", {31'd0, a_busy_flag}, 32'd0);
    check("poll_addr_cnt", {25'd0, a_addr_cnt}, 32'd3);
    check("poll_rd_data", {24'd0, a_rd_data}, 32'h03);
    check_after_done(1'b0, "poll");

    // Poll timeout on the 4 kHz / 2 ms instance with BF stuck high
    do_read(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 0, 0, lat, pulses, ehigh, bad, to);
    check("tmo_done_seen", {31'd0, lat > 0}, 32'd1);
    check("tmo_min_pulses", {31'd0, pulses >= 2}, 32'd1);
    check("tmo_min_elapsed", {31'd0, lat >= 9}, 32'd1);
    check("tmo_timeout_with_done", {31'd0, to}, 32'd1);
    check("tmo_bus_ctl", bad, 0);
    check("tmo_busy_flag", {31'd0, b_busy_flag}, 32'd1);
    check("tmo_addr_cnt", {25'd0, b_addr_cnt}, 32'h7F);
    check_after_done(1'b1, "tmo");

    // Reset during the E-high phase
    DB_in = 8'h25; rd_data_sel = 1'b0; poll_bf = 1'b0;
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (a_E) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rstmid_reached_ehigh", {31'd0, found}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_E", {31'd0, a_E}, 32'd0);
    check("rstmid_bus_own", {31'd0, a_bus_own}, 32'd0);
    check("rstmid_ready", {31'd0, a_ready}, 32'd1);
    check("rstmid_rd_data", {24'd0, a_rd_data}, 32'd0);
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_done) extra++;
      tick();
    end
    check("rstmid_no_done", extra, 0);

    // Request after reset completes; a stray req while busy is dropped
    do_read(1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 0, 3, lat, pulses, ehigh, bad, to);
    check("after_rst_latency", lat, 9);
    check("after_rst_pulses", pulses, 1);
    check("after_rst_bus_ctl", bad, 0);
    check("after_rst_rd_data", {24'd0, a_rd_data}, 32'h5A);
    check("after_rst_addr_cnt", {25'd0, a_addr_cnt}, 32'h5A);
    check_after_done(1'b0, "after_rst");
    waited = 0;
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      if (a_done) extra++;
      if (!a_ready || a_bus_own) waited++;
      tick();
    end
    check("busy_req_not_queued_done", extra, 0);
    check("busy_req_not_queued_idle", waited, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
